// File: rtl/tensor_pkg.sv
// Shared definitions for the tensor command sequencer: lane geometry, the op
// codes understood by the tensor lane unit, and the sequencer state encoding.
package tensor_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 4;
  localparam int DATA_W = LANE_W * LANES;

  typedef enum logic [1:0] {
    TS_MUL  = 2'b00,
    TS_FMA  = 2'b01,
    TS_RELU = 2'b10,
    TS_RSVD = 2'b11
  } ts_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_RELU   = 3'd2,
    ST_OUT    = 3'd3,
    ST_STREAM = 3'd4
  } state_e;

  // MUL and RELU produce one result per operand beat
  function automatic logic is_stream_op(input logic [1:0] op);
    return (op == TS_MUL) || (op == TS_RELU);
  endfunction

endpackage

// File: rtl/tensor_seq.sv
// Command sequencer feeding the combinational tensor lane unit.
// Optional feature macro: TENSOR_SEQ_FUSED_RELU_EN (fused ReLU on FMA results).
module tensor_seq
  import tensor_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_c,
  input  logic              cmd_relu,
  input  logic              opd_valid,
  output logic              opd_ready,
  input  logic [DATA_W-1:0] opd_a,
  input  logic [DATA_W-1:0] opd_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last,
  output logic              busy,
  output logic              ts_en,
  output logic [1:0]        ts_op,
  output logic [DATA_W-1:0] ts_a,
  output logic [DATA_W-1:0] ts_b,
  output logic [DATA_W-1:0] ts_c,
  input  logic [DATA_W-1:0] ts_out
);

  state_e              state_r, state_s;
  logic [1:0]          op_r, op_s;
  logic [LEN_W-1:0]    rem_r, rem_s;
  logic [DATA_W-1:0]   acc_r, acc_s;
  logic [DATA_W-1:0]   res_data_r, res_data_s;
  logic                res_valid_r, res_valid_s;
  logic                res_last_r, res_last_s;
  logic                opd_ready_s;
  logic                ts_en_s;
  logic [1:0]          ts_op_s;
  logic [DATA_W-1:0]   ts_a_s, ts_b_s, ts_c_s;
`ifdef TENSOR_SEQ_FUSED_RELU_EN
  logic                relu_r, relu_s;
`else
  logic                unused_relu_s;
  assign unused_relu_s = cmd_relu;
`endif

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign opd_ready = opd_ready_s;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_last  = res_last_r;
  assign ts_en     = ts_en_s;
  assign ts_op     = ts_op_s;
  assign ts_a      = ts_a_s;
  assign ts_b      = ts_b_s;
  assign ts_c      = ts_c_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, tensor-unit drive and datapath next values
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    rem_s       = rem_r;
    acc_s       = acc_r;
    res_data_s  = res_data_r;
    res_valid_s = res_valid_r;
    res_last_s  = res_last_r;
    opd_ready_s = 1'b0;
    ts_en_s     = 1'b0;
    ts_op_s     = 2'b00;
    ts_a_s      = {DATA_W{1'b0}};
    ts_b_s      = {DATA_W{1'b0}};
    ts_c_s      = {DATA_W{1'b0}};
`ifdef TENSOR_SEQ_FUSED_RELU_EN
    relu_s      = relu_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_s  = cmd_op;
          rem_s = cmd_len;
          acc_s = cmd_c;
`ifdef TENSOR_SEQ_FUSED_RELU_EN
          relu_s = cmd_relu;
`endif
          if (cmd_op == TS_FMA) begin
            if (cmd_len != {LEN_W{1'b0}}) begin
              state_s = ST_ACC;
`ifdef TENSOR_SEQ_FUSED_RELU_EN
            end else if (cmd_relu) begin
              state_s = ST_RELU;
`endif
            end else begin
              state_s     = ST_OUT;
              res_valid_s = 1'b1;
              res_data_s  = cmd_c;
              res_last_s  = 1'b1;
            end
          end else if (is_stream_op(cmd_op) && (cmd_len != {LEN_W{1'b0}})) begin
            state_s = ST_STREAM;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        opd_ready_s = 1'b1;
        ts_en_s     = 1'b1;
        ts_op_s     = TS_FMA;
        ts_a_s      = opd_a;
        ts_b_s      = opd_b;
        ts_c_s      = acc_r;
        if (opd_valid) begin
          acc_s = ts_out;
          rem_s = rem_r - LEN_W'(1);
          if (rem_r == LEN_W'(1)) begin
`ifdef TENSOR_SEQ_FUSED_RELU_EN
            if (relu_r) begin
              state_s = ST_RELU;
            end else begin
              state_s     = ST_OUT;
              res_valid_s = 1'b1;
              res_data_s  = ts_out;
              res_last_s  = 1'b1;
            end
`else
            state_s     = ST_OUT;
            res_valid_s = 1'b1;
            res_data_s  = ts_out;
            res_last_s  = 1'b1;
`endif
          end else begin
            state_s = ST_ACC;
          end
        end else begin
          state_s = ST_ACC;
        end
      end
`ifdef TENSOR_SEQ_FUSED_RELU_EN
      ST_RELU: begin
        ts_en_s     = 1'b1;
        ts_op_s     = TS_RELU;
        ts_a_s      = acc_r;
        acc_s       = ts_out;
        state_s     = ST_OUT;
        res_valid_s = 1'b1;
        res_data_s  = ts_out;
        res_last_s  = 1'b1;
      end
`endif
      ST_OUT: begin
        if (res_ready) begin
          state_s     = ST_IDLE;
          res_valid_s = 1'b0;
          res_last_s  = 1'b0;
        end else begin
          state_s = ST_OUT;
        end
      end
      ST_STREAM: begin
        // a held result blocks new beats so res_data stays stable under backpressure
        opd_ready_s = (rem_r != {LEN_W{1'b0}}) && (!res_valid_r || res_ready);
        if (opd_ready_s && opd_valid) begin
          ts_en_s     = 1'b1;
          ts_op_s     = op_r;
          ts_a_s      = opd_a;
          ts_b_s      = opd_b;
          res_data_s  = ts_out;
          res_valid_s = 1'b1;
          res_last_s  = (rem_r == LEN_W'(1));
          rem_s       = rem_r - LEN_W'(1);
        end else if (res_valid_r && res_ready) begin
          res_valid_s = 1'b0;
          res_last_s  = 1'b0;
        end else begin
          res_valid_s = res_valid_r;
        end
        if ((rem_r == {LEN_W{1'b0}}) && !res_valid_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STREAM;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath registers; reset aborts any command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r        <= 2'b00;
      rem_r       <= {LEN_W{1'b0}};
      acc_r       <= {DATA_W{1'b0}};
      res_data_r  <= {DATA_W{1'b0}};
      res_valid_r <= 1'b0;
      res_last_r  <= 1'b0;
`ifdef TENSOR_SEQ_FUSED_RELU_EN
      relu_r      <= 1'b0;
`endif
    end else begin
      op_r        <= op_s;
      rem_r       <= rem_s;
      acc_r       <= acc_s;
      res_data_r  <= res_data_s;
      res_valid_r <= res_valid_s;
      res_last_r  <= res_last_s;
`ifdef TENSOR_SEQ_FUSED_RELU_EN
      relu_r      <= relu_s;
`endif
    end
  end

endmodule

// File: tb/tb_tensor_seq.sv
// Self-checking bench for tensor_seq with a behavioural BF16 tensor lane model.
// Expectations for TENSOR_SEQ_FUSED_RELU_EN follow whether the macro is defined.
module tb_tensor_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_len;
  logic [63:0] cmd_c;
  logic        cmd_relu;
  logic        opd_valid, opd_ready;
  logic [63:0] opd_a, opd_b;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic        res_last, busy, ts_en;
  logic [1:0]  ts_op;
  logic [63:0] ts_a, ts_b, ts_c, ts_out;

  int errors = 0;
  int checks = 0;

  tensor_seq #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_c(cmd_c), .cmd_relu(cmd_relu),
    .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy),
    .ts_en(ts_en), .ts_op(ts_op), .ts_a(ts_a), .ts_b(ts_b), .ts_c(ts_c),
    .ts_out(ts_out)
  );

  always #5 clk = ~clk;

  function automatic real bf2r(input logic [15:0] h);
    logic [63:0] bits;
    if (h[14:7] == 8'd0) return 0.0;
    bits = {h[15], 11'({3'b000, h[14:7]} + 11'd896), h[6:0], 45'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] bits;
    logic [10:0] e;
    if (r == 0.0) return 16'h0000;
    bits = $realtobits(r);
    e = bits[62:52] - 11'd896;
    return {bits[63], e[7:0], bits[51:45]};
  endfunction

  function automatic logic [15:0] lane_op(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] c);
    case (op)
      2'b00:   return r2bf(bf2r(a) * bf2r(b));
      2'b01:   return r2bf(bf2r(a) * bf2r(b) + bf2r(c));
      2'b10:   return a[15] ? 16'h0000 : a;
      default: return 16'h0000;
    endcase
  endfunction

  // Tensor lane unit reference
  always_comb begin
    ts_out = 64'd0;
    if (ts_en) begin
      for (int l = 0; l < 4; l++)
        ts_out[l*16 +: 16] = lane_op(ts_op, ts_a[l*16 +: 16], ts_b[l*16 +: 16], ts_c[l*16 +: 16]);
    end
  end

  function automatic logic [63:0] rep4(input logic [15:0] h);
    return {h, h, h, h};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  len;
    logic [15:0] c;
    logic        relu;
    logic [15:0] a0, b0, a1, b1;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  // Issue one command, feed its beats with res_ready=1, check every result
  task automatic run_cmd(input vec_t v, input int idx);
    bit fired = 0;
    bit done = 0;
    int cyc = 0, sent = 0, nres = 0, first = -1, end_cyc = -1, nexp;
    nexp = (v.op == 2'b01) ? 1 : (v.op == 2'b11) ? 0 : int'(v.len);
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      cmd_valid = !fired;
      cmd_op    = v.op;
      cmd_len   = v.len;
      cmd_c     = rep4(v.c);
      cmd_relu  = v.relu;
      opd_valid = (sent < int'(v.len));
      opd_a     = rep4(sent == 0 ? v.a0 : v.a1);
      opd_b     = rep4(sent == 0 ? v.b0 : v.b1);
      res_ready = 1'b1;
      #1;
      if (fired) cyc++;
      if (!fired && cmd_ready) begin
        fired = 1;
        cyc = 0;
      end else if (fired && cmd_ready) begin
        done = 1;
        end_cyc = cyc;
      end
      if (opd_valid && opd_ready) sent++;
      if (res_valid && res_ready) begin
        if (nres == 0) first = cyc;
        chk($sformatf("v%0d data", idx), res_data, rep4(v.exp));
        chk($sformatf("v%0d last", idx), 64'(res_last), 64'(nres == nexp - 1));
        nres++;
      end
    end
    cmd_valid = 1'b0;
    opd_valid = 1'b0;
    chk($sformatf("v%0d completed", idx), 64'(done), 64'd1);
    chk($sformatf("v%0d result count", idx), 64'(nres), 64'(nexp));
    chk($sformatf("v%0d beats consumed", idx), 64'(sent), 64'((v.op == 2'b11) ? 0 : int'(v.len)));
    chk($sformatf("v%0d latency", idx), 64'(first), 64'(v.lat));
    if (nexp == 0) chk($sformatf("v%0d idle next cycle", idx), 64'(end_cyc), 64'd1);
  endtask

  initial begin
    // op, len, c, relu, a0, b0, a1, b1, expected lane, first-result cycle
    vecs[0]  = '{2'b01, 8'd2, 16'h0000, 1'b0, 16'h3F80, 16'h4000, 16'h3F80, 16'h4040, 16'h40A0, 3};
    vecs[1]  = '{2'b01, 8'd0, 16'h3F80, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3F80, 1};
    vecs[2]  = '{2'b00, 8'd1, 16'h0000, 1'b0, 16'h4000, 16'h4040, 16'h4000, 16'h4040, 16'h40C0, 2};
    vecs[3]  = '{2'b00, 8'd2, 16'h0000, 1'b0, 16'hBF80, 16'hC000, 16'hBF80, 16'hC000, 16'h4000, 2};
    vecs[4]  = '{2'b10, 8'd1, 16'h0000, 1'b0, 16'hC000, 16'h0000, 16'hC000, 16'h0000, 16'h0000, 2};
    vecs[5]  = '{2'b10, 8'd3, 16'h0000, 1'b0, 16'h4040, 16'h0000, 16'h4040, 16'h0000, 16'h4040, 2};
    vecs[6]  = '{2'b01, 8'd1, 16'h40A0, 1'b0, 16'hBF80, 16'h4000, 16'hBF80, 16'h4000, 16'h4040, 2};
    vecs[7]  = '{2'b01, 8'd3, 16'hBF80, 1'b0, 16'h3F80, 16'h4000, 16'h3F80, 16'h4000, 16'h40A0, 4};
    vecs[8]  = '{2'b11, 8'd4, 16'h0000, 1'b0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0000, -1};
    vecs[9]  = '{2'b00, 8'd0, 16'h0000, 1'b0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0000, -1};
`ifdef TENSOR_SEQ_FUSED_RELU_EN
    vecs[10] = '{2'b01, 8'd1, 16'h0000, 1'b1, 16'hBF80, 16'h4000, 16'hBF80, 16'h4000, 16'h0000, 3};
    vecs[11] = '{2'b01, 8'd1, 16'h0000, 1'b1, 16'h3F80, 16'h4000, 16'h3F80, 16'h4000, 16'h4000, 3};
`else
    vecs[10] = '{2'b01, 8'd1, 16'h0000, 1'b1, 16'hBF80, 16'h4000, 16'hBF80, 16'h4000, 16'hC000, 2};
    vecs[11] = '{2'b01, 8'd1, 16'h0000, 1'b1, 16'h3F80, 16'h4000, 16'h3F80, 16'h4000, 16'h4000, 2};
`endif

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 8'd0; cmd_c = 64'd0;
    cmd_relu = 1'b0; opd_valid = 1'b0; opd_a = 64'd0; opd_b = 64'd0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset opd_ready", 64'(opd_ready), 64'd0);
    chk("reset res_valid", 64'(res_valid), 64'd0);
    chk("reset res_last", 64'(res_last), 64'd0);
    chk("reset res_data", res_data, 64'd0);
    chk("reset ts_en", 64'(ts_en), 64'd0);
    chk("reset ts_op", 64'(ts_op), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_cmd(vecs[i], i);

    // MUL K=3 with the first result held for two cycles
    begin
      int sent = 0, nres = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = 8'd3; res_ready = 1'b1;
      #1;
      chk("bp cmd_ready", 64'(cmd_ready), 64'd1);
      for (int cyc = 1; cyc < 40 && !(nres == 3 && cmd_ready); cyc++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        opd_valid = (sent < 3);
        opd_a = rep4(16'h4000);
        opd_b = rep4(16'h4040);
        res_ready = !(cyc == 2 || cyc == 3);
        #1;
        if (!res_ready) begin
          chk("bp valid held", 64'(res_valid), 64'd1);
          chk("bp no opd accept", 64'(opd_ready), 64'd0);
          chk("bp data held", res_data, rep4(16'h40C0));
          chk("bp ts quiet", {63'd0, ts_en} | ts_a, 64'd0);
        end
        if (opd_valid && opd_ready) sent++;
        if (res_valid && res_ready) begin
          chk("bp data", res_data, rep4(16'h40C0));
          chk("bp last", 64'(res_last), 64'(nres == 2));
          nres++;
        end
      end
      opd_valid = 1'b0;
      chk("bp result count", 64'(nres), 64'd3);
      chk("bp beats consumed", 64'(sent), 64'd3);
    end

    // Reset in the middle of an FMA accumulation
    begin
      int rises = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 8'd3; cmd_c = 64'd0; cmd_relu = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0; opd_valid = 1'b1; opd_a = rep4(16'h3F80); opd_b = rep4(16'h4000);
      #1;
      chk("rst accepts beat", 64'(opd_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst opd_ready", 64'(opd_ready), 64'd0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        #1;
        if (res_valid) rises++;
      end
      opd_valid = 1'b0;
      chk("rst no result", 64'(rises), 64'd0);
      run_cmd('{2'b01, 8'd1, 16'h0000, 1'b0, 16'h3F80, 16'h4040, 16'h3F80, 16'h4040,
                16'h4040, 2}, 99);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
